// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: PS/2 scan-code fetch and key-press decoder.
// Pulls bytes from a receiver FIFO (ps2_ready / nextdata_n), tracks the
// currently held key, counts distinct presses and flags receiver overflow.
// Optional feature macro: KBD_EXT_CODE_EN enables E0-prefixed (extended)
// key tracking; without it E0 bytes are popped and discarded.
//
// Handshake: the receiver presents a byte on ps2_data while ps2_ready=1.
// The byte is consumed at the rising edge where the FSM is in IDLE and
// ps2_ready=1; nextdata_n is then low for exactly the following cycle
// (POP) to pop the FIFO head, and the next cycle (DRAIN) ignores ps2_ready
// so the receiver has time to update its head/ready after the pop.
module kbd_scan_ctrl (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_ready,
  input  logic       ps2_overflow,
  output logic       nextdata_n,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_ext,
  output logic [7:0] key_count,
  output logic       make_pulse,
  output logic       break_pulse,
  output logic       ovf_seen
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POP   = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  // Current fetch state; named so checkers can bind to it directly.
  fetch_state_t fsm_state;
  fetch_state_t fsm_state_nxt;

  logic brk_q;
  logic capture;
  logic is_f0;
  logic is_e0;
  logic ext_match;
  logic code_match;

  assign capture = (fsm_state == ST_IDLE) && ps2_ready;
  assign is_f0   = (ps2_data == 8'hF0);
  assign is_e0   = (ps2_data == 8'hE0);

`ifdef KBD_EXT_CODE_EN
  logic ext_q;
  logic key_ext_q;
  assign ext_match = (ext_q == key_ext_q);
  assign key_ext   = key_ext_q;
`else
  assign ext_match = 1'b1;
  assign key_ext   = 1'b0;
`endif

  assign code_match = (ps2_data == key_code) && ext_match;

  // Fetch state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      fsm_state <= ST_IDLE;
    end else begin
      fsm_state <= fsm_state_nxt;
    end
  end

  // Fetch next-state and pop strobe: low only while in POP.
  always_comb begin
    fsm_state_nxt = fsm_state;
    nextdata_n    = 1'b1;
    case (fsm_state)
      ST_IDLE: begin
        if (ps2_ready) fsm_state_nxt = ST_POP;
      end
      ST_POP: begin
        nextdata_n    = 1'b0;
        fsm_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        fsm_state_nxt = ST_IDLE;
      end
      default: begin
        fsm_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Decode the byte at the capture edge: prefixes set flags, other bytes
  // are make/break codes against the held key.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      brk_q       <= 1'b0;
      key_code    <= 8'h00;
      key_valid   <= 1'b0;
      key_count   <= 8'h00;
      make_pulse  <= 1'b0;
      break_pulse <= 1'b0;
`ifdef KBD_EXT_CODE_EN
      ext_q       <= 1'b0;
      key_ext_q   <= 1'b0;
`endif
    end else begin
      make_pulse  <= 1'b0;
      break_pulse <= 1'b0;
      if (capture) begin
        if (is_f0) begin
          brk_q <= 1'b1;
        end else if (is_e0) begin
`ifdef KBD_EXT_CODE_EN
          ext_q <= 1'b1;
`endif
        end else begin
          brk_q <= 1'b0;
`ifdef KBD_EXT_CODE_EN
          ext_q <= 1'b0;
`endif
          if (!brk_q) begin
            // Typematic repeats of the held key are swallowed here.
            if (!key_valid || !code_match) begin
              key_code   <= ps2_data;
              key_valid  <= 1'b1;
              key_count  <= key_count + 8'd1;
              make_pulse <= 1'b1;
`ifdef KBD_EXT_CODE_EN
              key_ext_q  <= ext_q;
`endif
            end
          end else if (key_valid && code_match) begin
            // Release of the held key; code/ext stay for inspection.
            key_valid   <= 1'b0;
            break_pulse <= 1'b1;
          end
        end
      end
    end
  end

  // Sticky receiver-overflow indication, cleared only by reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ovf_seen <= 1'b0;
    end else if (ps2_overflow) begin
      ovf_seen <= 1'b1;
    end
  end

endmodule

// File: doc/kbd_scan_ctrl.md
KBD_SCAN_CTRL -- requirements
Module: kbd_scan_ctrl

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning (clock and reset first):
  clk          input   1  system clock; all state on rising edge
  clrn         input   1  asynchronous active-low reset
  ps2_data     input   8  received scan-code byte from the PS/2 receiver FIFO head
  ps2_ready    input   1  receiver FIFO non-empty
  ps2_overflow input   1  receiver FIFO overflow flag
  nextdata_n   output  1  active-low pop strobe to the receiver
  key_code     output  8  last accepted make code
  key_valid    output  1  key_code currently held
  key_ext      output  1  key_code carried an E0 prefix
  key_count    output  8  number of distinct key presses, modulo 256
  make_pulse   output  1  one-cycle strobe on a counted press
  break_pulse  output  1  one-cycle strobe on release of the held key
  ovf_seen     output  1  sticky receiver-overflow indication

Function
REQ-002 The fetch FSM SHALL have the states IDLE, POP and DRAIN, and SHALL reset to IDLE.
REQ-003 In IDLE with ps2_ready=1, the block SHALL capture ps2_data and go to POP.
REQ-004 In POP, nextdata_n SHALL be 0 for exactly one cycle, and the FSM SHALL then go to DRAIN.
REQ-005 In DRAIN, the FSM SHALL hold nextdata_n=1, ignore ps2_ready for one cycle, and then return to IDLE; maximum throughput is therefore one byte per 3 cycles.
REQ-006 A captured byte SHALL be decoded at the clock edge that enters POP, so its outputs are visible one cycle after ps2_ready is sampled high.
REQ-007 A byte of 8'hF0 SHALL set the internal brk flag and change no output.
REQ-008 A non-prefix byte with brk=0 SHALL be a make code.
REQ-009 A make code SHALL count as a press if key_valid=0, or if it differs from key_code or key_ext; a press sets key_code to the byte, sets key_valid=1, increments key_count and asserts make_pulse for 1 cycle.
REQ-010 A make code equal to the held key (typematic repeat) SHALL change no output.
REQ-011 A non-prefix byte with brk=1 SHALL be a break code.
REQ-012 If a break code matches key_code and key_ext while key_valid=1, the block SHALL clear key_valid and assert break_pulse for 1 cycle; key_code and key_ext SHALL retain their values.
REQ-013 A non-matching break code SHALL be ignored.
REQ-014 Every non-prefix byte SHALL clear the brk flag and the ext flag.
REQ-015 Rollover: a different make code while a key is held SHALL replace the held key and count; the later break of the old key SHALL be ignored.
REQ-016 key_count SHALL wrap from 255 to 0 with no flag.
REQ-017 make_pulse and break_pulse SHALL never be high in the same cycle.
REQ-018 ovf_seen SHALL set on any cycle with ps2_overflow=1 and SHALL clear only on reset; decoding SHALL continue normally while it is set.
REQ-019 nextdata_n SHALL never be 0 in IDLE or DRAIN, or while clrn=0.

Reset
REQ-020 While clrn=0, regardless of clk, the block SHALL force: nextdata_n=1, key_code=8'h00, key_valid=0, key_ext=0, key_count=8'h00, make_pulse=0, break_pulse=0, ovf_seen=0, brk=0, ext=0, FSM=IDLE.
REQ-021 Reset asserted mid-sequence (for example between F0 and the following code) SHALL discard the pending prefix; the first byte after release SHALL be decoded as a make code.
REQ-022 The first capture after reset release SHALL occur no earlier than the first rising edge with clrn=1.

Configuration
REQ-023 When macro KBD_EXT_CODE_EN is defined, a byte of 8'hE0 SHALL set the ext flag and change no output.
REQ-024 When KBD_EXT_CODE_EN is defined, a press SHALL load key_ext from the ext flag, and make/break matching SHALL compare both key_code and key_ext.
REQ-025 When KBD_EXT_CODE_EN is undefined, 8'hE0 SHALL be popped and discarded with no state change, key_ext SHALL be tied to 0, and matching SHALL use key_code only.

Verification
REQ-026 Send 1C, F0, 1C -> key_code=1C; key_count 0->1; one make_pulse, then one break_pulse; key_valid ends at 0.
REQ-027 Send 1B, 1B, 1B, F0, 1B -> key_count=1; exactly one make_pulse; exactly three nextdata_n low pulses before the F0.
REQ-028 Send 1C, 1B, F0, 1C, F0, 1B -> key_count=2; key_code=1B; the F0 1C pair produces no break_pulse; the F0 1B pair produces break_pulse.
REQ-029 With KBD_EXT_CODE_EN defined, send E0 75, F0 75, E0 F0 75 -> the F0 75 pair produces no break_pulse; E0 F0 75 produces break_pulse; key_ext=1.
REQ-030 Perform 256 distinct press/release pairs -> key_count wraps to 8'h00; a single ps2_overflow pulse -> ovf_seen stays 1 until clrn=0.
REQ-031 Assert clrn=0 after F0 is received, release it, then send 1C -> key_valid=1, key_count=1, no break_pulse.
